// File: rtl/if_id_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_id_fetch_stage
// Instruction-fetch stage and IF/ID pipeline register. This block owns the PC,
// runs a req/ready handshake to the instruction cache, and hands the fetched
// instruction and its PC to decode. It handles load-use stalls, data-cache
// stalls and branch flush/redirect, including a redirect that arrives while a
// fetch is still outstanding.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   stall_i               load-use hold from the hazard unit
//   mem_stall_i           data-cache miss; freezes IF/ID and masks flush_i
//   flush_i               branch taken in ID; branch_target_i is the new PC
//   imem_req_o/addr_o     fetch request and address (addr == pc_q)
//   imem_ready_i/data_i   fetch completion; data valid in the ready cycle
//   id_instr_o/pc_o/valid_o  IF/ID register contents
//
// Optional feature (macro IF_PERF_CNT_EN):
//   flush_cnt_o           accepted flushes (flush_i & ~mem_stall_i)
//   fetch_wait_cnt_o      cycles with imem_req_o=1 and imem_ready_i=0
//
// state | meaning
// FETCH | request outstanding on pc_q, IF/ID updated on ready
// HOLD  | fetched word parked in skid buffer while decode is stalled
// DRAIN | redirect pending; waiting for the stale fetch to finish
// ----------------------------------------------------------------------------
module if_id_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        mem_stall_i,
    input  logic        flush_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    output logic        id_valid_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] flush_cnt_o,
    output logic [31:0] fetch_wait_cnt_o
`endif
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        id_valid_q, id_valid_d;

    logic adv;
    logic flush_eff;
    logic bubble;

    // A data-cache stall outranks flush; the pipeline keeps flush_i high
    // until it can be taken.
    assign adv       = ~stall_i & ~mem_stall_i;
    assign flush_eff = flush_i & ~mem_stall_i;

    assign imem_req_o  = (state_q != HOLD);
    assign imem_addr_o = pc_q;
    assign id_instr_o  = id_instr_q;
    assign id_pc_o     = id_pc_q;
    assign id_valid_o  = id_valid_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        tgt_d        = tgt_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        id_valid_d   = id_valid_q;
        bubble       = 1'b0;

        case (state_q)
            FETCH: begin
                if (imem_ready_i) begin
                    if (flush_eff) begin
                        pc_d   = branch_target_i;
                        bubble = 1'b1;
                    end else if (adv) begin
                        id_instr_d = imem_data_i;
                        id_pc_d    = pc_q;
                        id_valid_d = 1'b1;
                        pc_d       = pc_q + 32'd4;
                    end else begin
                        skid_instr_d = imem_data_i;
                        skid_pc_d    = pc_q;
                        pc_d         = pc_q + 32'd4;
                        state_d      = HOLD;
                    end
                end else if (flush_eff) begin
                    tgt_d   = branch_target_i;
                    bubble  = 1'b1;
                    state_d = DRAIN;
                end else if (adv) begin
                    bubble = 1'b1;
                end
            end
            HOLD: begin
                // pc_q already points past the parked word, so a flush simply
                // replaces it.
                if (flush_eff) begin
                    pc_d    = branch_target_i;
                    bubble  = 1'b1;
                    state_d = FETCH;
                end else if (adv) begin
                    id_instr_d = skid_instr_q;
                    id_pc_d    = skid_pc_q;
                    id_valid_d = 1'b1;
                    state_d    = FETCH;
                end
            end
            DRAIN: begin
                // The request stays on the stale address until the cache
                // answers; a newer flush supersedes the pending target.
                if (flush_eff) begin
                    tgt_d = branch_target_i;
                end
                if (imem_ready_i) begin
                    pc_d    = flush_eff ? branch_target_i : tgt_q;
                    state_d = FETCH;
                end
                bubble = adv | flush_eff;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        if (bubble) begin
            id_instr_d = NOP_INSTR;
            id_pc_d    = 32'd0;
            id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            tgt_q        <= 32'd0;
            skid_instr_q <= 32'd0;
            skid_pc_q    <= 32'd0;
            id_instr_q   <= NOP_INSTR;
            id_pc_q      <= 32'd0;
            id_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            tgt_q        <= tgt_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
            id_valid_q   <= id_valid_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flush_cnt_o      <= 32'd0;
            fetch_wait_cnt_o <= 32'd0;
        end else begin
            if (flush_eff) begin
                flush_cnt_o <= flush_cnt_o + 32'd1;
            end
            if (imem_req_o && !imem_ready_i) begin
                fetch_wait_cnt_o <= fetch_wait_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule
